systolic_ctrl: RTL

Sequencer for the D×D output-stationary systolic array. It clears the array accumulators and accepts D operand beats over a valid/ready handshake, where each beat is one column of A and one row of B. It applies the diagonal skew, so lane i is delayed i cycles, onto the array's left and top edges, waits for the wavefront to drain, then flags the results valid until acknowledged. It sits between the operand buffers and the array; the integrator drives the array reset with rst | arr_clr.

---
 rtl/systolic_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/systolic_ctrl.sv
// Job sequencer for a DxD output-stationary systolic array: clears the accumulators,
// takes D operand beats, skews them onto the array edges, drains, then holds results.
module systolic_ctrl #(
   parameter int K     = 8,
   parameter int D     = 16,
   parameter int DRAIN = 3*D-1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [D*K-1:0] a_in,
   input  logic [D*K-1:0] b_in,
   input  logic           in_valid,
   output logic           in_ready,
   output logic           arr_clr,
   output logic [D*K-1:0] arr_l,
   output logic [D*K-1:0] arr_t,
   output logic           busy,
   output logic           res_valid,
   input  logic           res_ack,
   output logic [2:0]     dbg_state
);

   localparam int BW = $clog2(D + 1);
   localparam int DW = $clog2(DRAIN + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] beat_cnt_q, beat_cnt_d;
   logic [DW-1:0] drain_cnt_q, drain_cnt_d;
   logic          accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         beat_cnt_q  <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // Operand handshake: a beat transfers on every rising edge where in_valid and
   // in_ready are both high; in_ready is a pure decode of state, never of in_valid.
   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      drain_cnt_d = drain_cnt_q;
      in_ready    = 1'b0;
      arr_clr     = 1'b0;
      res_valid   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            arr_clr    = 1'b1;
            beat_cnt_d = '0;
            state_d    = S_FEED;
         end
         S_FEED: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (beat_cnt_q == BW'(D - 1)) begin
                  beat_cnt_d  = '0;
                  drain_cnt_d = '0;
                  state_d     = S_DRAIN;
               end else begin
                  beat_cnt_d = beat_cnt_q + BW'(1);
               end
            end
         end
         S_DRAIN: begin
            if (drain_cnt_q == DW'(DRAIN - 1)) begin
               drain_cnt_d = '0;
               state_d     = S_DONE;
            end else begin
               drain_cnt_d = drain_cnt_q + DW'(1);
            end
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign accept    = in_valid & in_ready;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

   // Lane i is delayed i+1 registers; non-accepted cycles shift in zeros, which the
   // array accumulates as zero products.
   for (genvar i = 0; i < D; i++) begin : g_lane
      logic [K-1:0] a_sr_q [i+1];
      logic [K-1:0] b_sr_q [i+1];
      logic [K-1:0] a_sr_d, b_sr_d;

      assign a_sr_d = accept ? a_in[i*K +: K] : '0;
      assign b_sr_d = accept ? b_in[i*K +: K] : '0;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int s = 0; s <= i; s++) begin
               a_sr_q[s] <= '0;
               b_sr_q[s] <= '0;
            end
         end else begin
            a_sr_q[0] <= a_sr_d;
            b_sr_q[0] <= b_sr_d;
            for (int s = 1; s <= i; s++) begin
               a_sr_q[s] <= a_sr_q[s-1];
               b_sr_q[s] <= b_sr_q[s-1];
            end
         end
      end

      assign arr_l[i*K +: K] = a_sr_q[i];
      assign arr_t[i*K +: K] = b_sr_q[i];
   end

endmodule
